// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing PIO: register map, edge selection
// and bus data width.
package pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Multi-stage input synchroniser followed by a per-bit edge detector whose
// polarity is fixed at elaboration time.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] det
);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;

  // Synchroniser chain plus one extra sample for edge comparison
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_r[SYNC_STAGES-1];

  // Edge selection
  always_comb begin
    rise_s = in_sync & ~prev_r;
    fall_s = ~in_sync & prev_r;
    case (EDGE_TYPE)
      EDGE_FALL: det = fall_s;
      EDGE_ANY:  det = rise_s | fall_s;
      default:   det = rise_s;
    endcase
  end

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM PIO with synchronised inputs, sticky edge capture, masked level
// interrupt and a set/clear-able output register.
module pio_edge_irq
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  logic [WIDTH-1:0]  in_sync_s;
  logic [WIDTH-1:0]  det_s;
  logic [WIDTH-1:0]  out_r;
  logic [WIDTH-1:0]  irqmask_r;
  logic [WIDTH-1:0]  edgecap_r;
  logic [DATA_W-1:0] readdata_r;
  logic              irq_r;

  logic              wr_en_s;
  logic [WIDTH-1:0]  wdata_s;
  logic [WIDTH-1:0]  clr_s;
  logic [WIDTH-1:0]  out_nxt_s;
  logic [WIDTH-1:0]  irqmask_nxt_s;
  logic [WIDTH-1:0]  edgecap_nxt_s;
  logic [DATA_W-1:0] rdata_nxt_s;
  logic              unused_wdata_s;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .in_sync(in_sync_s),
    .det    (det_s)
  );

  assign wr_en_s        = chipselect & write;
  assign wdata_s        = writedata[WIDTH-1:0];
  assign unused_wdata_s = ^writedata;

  // Register write decode; a new edge overrides a same-cycle clear
  always_comb begin
    out_nxt_s     = out_r;
    irqmask_nxt_s = irqmask_r;
    clr_s         = '0;
    if (wr_en_s) begin
      case (address)
        ADDR_OUT:     out_nxt_s     = wdata_s;
        ADDR_IRQMASK: irqmask_nxt_s = wdata_s;
        ADDR_EDGECAP: clr_s         = wdata_s;
        ADDR_OUTSET:  out_nxt_s     = out_r | wdata_s;
        ADDR_OUTCLR:  out_nxt_s     = out_r & ~wdata_s;
        default:      out_nxt_s     = out_r;
      endcase
    end else begin
      out_nxt_s = out_r;
    end
    edgecap_nxt_s = (edgecap_r & ~clr_s) | det_s;
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rdata_nxt_s = '0;
    case (address)
      ADDR_DATA:    rdata_nxt_s[WIDTH-1:0] = in_sync_s;
      ADDR_OUT:     rdata_nxt_s[WIDTH-1:0] = out_r;
      ADDR_IRQMASK: rdata_nxt_s[WIDTH-1:0] = irqmask_r;
      ADDR_EDGECAP: rdata_nxt_s[WIDTH-1:0] = edgecap_r;
      default:      rdata_nxt_s            = '0;
    endcase
  end

  // Register file, read data and interrupt state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r      <= OUT_RESET;
      irqmask_r  <= '0;
      edgecap_r  <= '0;
      readdata_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      out_r      <= out_nxt_s;
      irqmask_r  <= irqmask_nxt_s;
      edgecap_r  <= edgecap_nxt_s;
      readdata_r <= rdata_nxt_s;
      irq_r      <= |(edgecap_r & irqmask_r);
    end
  end

  assign readdata = readdata_r;
  assign out_port = out_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_pio_edge_irq.sv
// Directed and randomized bench for pio_edge_irq: a rising-edge and an
// any-edge instance share one bus and are tracked by a cycle reference model.
module tb_pio_edge_irq;
  import pio_pkg::*;

  localparam int W   = 4;
  localparam int SS0 = 2;
  localparam int SS1 = 3;
  localparam logic [3:0] OR0 = 4'h0;
  localparam logic [3:0] OR1 = 4'h6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [3:0]  in_port = 4'h0;
  logic [31:0] rd0, rd1;
  logic [3:0]  out0, out1;
  logic        irq0, irq1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_edge_irq #(.WIDTH(W), .SYNC_STAGES(SS0), .EDGE_TYPE(EDGE_RISE), .OUT_RESET(OR0)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(rd0), .in_port(in_port), .out_port(out0), .irq(irq0));

  pio_edge_irq #(.WIDTH(W), .SYNC_STAGES(SS1), .EDGE_TYPE(EDGE_ANY), .OUT_RESET(OR1)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(rd1), .in_port(in_port), .out_port(out1), .irq(irq1));

  // Reference model: h[i][k] is in_port as sampled k+1 clock edges ago
  int          ss[2]  = '{SS0, SS1};
  int          et[2]  = '{EDGE_RISE, EDGE_ANY};
  logic [3:0]  orv[2] = '{OR0, OR1};
  logic [3:0]  h[2][5];
  logic [3:0]  m_cap[2], m_mask[2], m_out[2];
  logic [31:0] m_rd[2];
  logic        m_irq[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 5; j++) h[i][j] = 4'h0;
      m_cap[i] = 4'h0; m_mask[i] = 4'h0; m_out[i] = orv[i];
      m_rd[i] = 32'h0; m_irq[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] sy, pv, det, wd;
    logic we;
    we = chipselect && write;
    wd = writedata[3:0];
    for (int i = 0; i < 2; i++) begin
      sy = h[i][ss[i]-1];
      pv = h[i][ss[i]];
      case (et[i])
        EDGE_RISE: det = sy & ~pv;
        EDGE_FALL: det = ~sy & pv;
        default:   det = sy ^ pv;
      endcase
      case (address)
        3'd0:    m_rd[i] = {28'h0, sy};
        3'd1:    m_rd[i] = {28'h0, m_out[i]};
        3'd2:    m_rd[i] = {28'h0, m_mask[i]};
        3'd3:    m_rd[i] = {28'h0, m_cap[i]};
        default: m_rd[i] = 32'h0;
      endcase
      m_irq[i] = |(m_cap[i] & m_mask[i]);
      if (we) begin
        case (address)
          3'd1:    m_out[i]  = wd;
          3'd2:    m_mask[i] = wd;
          3'd3:    m_cap[i]  = m_cap[i] & ~wd;
          3'd4:    m_out[i]  = m_out[i] | wd;
          3'd5:    m_out[i]  = m_out[i] & ~wd;
          default: ;
        endcase
      end
      m_cap[i] = m_cap[i] | det;
      for (int j = 4; j > 0; j--) h[i][j] = h[i][j-1];
      h[i][0] = in_port;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("m_rd_rise",  rd0, m_rd[0]);
    chk("m_out_rise", {28'h0, out0}, {28'h0, m_out[0]});
    chk("m_irq_rise", {31'h0, irq0}, {31'h0, m_irq[0]});
    chk("m_rd_any",   rd1, m_rd[1]);
    chk("m_out_any",  {28'h0, out1}, {28'h0, m_out[1]});
    chk("m_irq_any",  {31'h0, irq1}, {31'h0, m_irq[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #2;
    chk_model();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      tick();
      chk("rst_rd_rise", rd0, 32'h0);
      chk("rst_rd_any", rd1, (a == 1) ? 32'h6 : 32'h0);
    end
    chk("rst_out_rise", {28'h0, out0}, 32'h0);
    chk("rst_out_any", {28'h0, out1}, 32'h6);
    chk("rst_irq", {31'h0, irq0}, 32'h0);

    // Rising capture latency and irq one cycle later
    wr(3'd2, 32'h5);
    address = 3'd3;
    in_port = 4'h1;
    tick(); tick();
    tick();
    chk("lat_rd_before", rd0, 32'h0);
    chk("lat_irq_before", {31'h0, irq0}, 32'h0);
    tick();
    chk("lat_cap", rd0, 32'h1);
    chk("lat_irq", {31'h0, irq0}, 32'h1);
    in_port = 4'h0;
    repeat (4) tick();
    chk("fall_no_cap", rd0, 32'h1);

    // Clear coinciding with a new rising edge: set wins
    in_port = 4'h1;
    tick(); tick();
    wr(3'd3, 32'h1);
    tick();
    chk("setwins_cap", rd0, 32'h1);
    chk("setwins_irq", {31'h0, irq0}, 32'h1);
    wr(3'd3, 32'h1);
    chk("clr_irq_hold", {31'h0, irq0}, 32'h1);
    tick();
    chk("clr_cap", rd0, 32'h0);
    chk("clr_irq", {31'h0, irq0}, 32'h0);

    // Any-edge: two separate captures on bit 2, mask 0 keeps irq low
    wr(3'd3, 32'hF);
    wr(3'd2, 32'h0);
    address = 3'd3;
    in_port = 4'h5;
    repeat (6) tick();
    chk("any_up_cap", rd1, 32'h4);
    chk("any_up_irq", {31'h0, irq1}, 32'h0);
    wr(3'd3, 32'h4);
    repeat (2) tick();
    chk("any_clr", rd1, 32'h0);
    in_port = 4'h1;
    repeat (6) tick();
    chk("any_dn_cap", rd1, 32'h4);
    chk("rise_dn_nocap", rd0, 32'h0);
    chk("any_dn_irq", {31'h0, irq1}, 32'h0);
    wr(3'd2, 32'h4);
    chk("mask_irq_now", {31'h0, irq1}, 32'h0);
    tick();
    chk("mask_irq_next", {31'h1 & 31'h0, irq1}, 32'h1);

    // Output register load / set / clear
    wr(3'd1, 32'hA);
    chk("out_load", {28'h0, out0}, 32'hA);
    wr(3'd4, 32'h1);
    chk("out_set", {28'h0, out1}, 32'hB);
    wr(3'd5, 32'h8);
    chk("out_clr", {28'h0, out0}, 32'h3);
    address = 3'd1;
    tick();
    chk("out_read", rd0, 32'h3);
    writedata = 32'hF; write = 1'b1; chipselect = 1'b0;
    tick();
    address = 3'd4;
    tick();
    write = 1'b0;
    chk("cs_low", {28'h0, out0}, 32'h3);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      in_port    = 4'($urandom);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 2) == 0);
      write      = 1'($urandom_range(0, 1));
      tick();
    end
    chipselect = 1'b0; write = 1'b0;

    // Async reset with captures pending and outputs driven
    wr(3'd1, 32'h3);
    wr(3'd3, 32'hF);
    in_port = 4'h0;
    repeat (5) tick();
    wr(3'd3, 32'hF);
    in_port = 4'hF;
    wr(3'd2, 32'hF);
    address = 3'd3;
    repeat (6) tick();
    chk("pre_rst_cap", rd1, 32'hF);
    chk("pre_rst_out", {28'h0, out1}, 32'h3);
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_rd", rd1, 32'h0);
    chk("arst_out_any", {28'h0, out1}, 32'h6);
    chk("arst_out_rise", {28'h0, out0}, 32'h0);
    chk("arst_irq", {31'h0, irq1}, 32'h0);
    chk_model();
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("post_rst_cap_rise", rd0, 32'hF);
    chk("post_rst_cap_any", rd1, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
